// File: rtl/cmd_frame_parser.sv
`default_nettype none
// ============================================================================
// cmd_frame_parser : decodes UART command frames into registered config writes
// Rev 1.0
// ============================================================================
module cmd_frame_parser #(
  parameter int          DATA_BIT    = 32,
  parameter int          OUTPUT_NUM  = 16,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  CMD_DATA    = 8'h01,
  parameter logic [7:0]  CMD_CTRL    = 8'h02,
  parameter logic [7:0]  CMD_FREQ    = 8'h03,
  parameter logic [7:0]  CMD_PERIOD  = 8'h04,
  parameter logic [7:0]  DEF_SLOW    = 8'h14,
  parameter logic [7:0]  DEF_FAST    = 8'h05,
  localparam int         CH_W        = $clog2(OUTPUT_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data_i,
  input  logic                rx_done_tick_i,
  output logic                freq_we_o,
  output logic [DATA_BIT-1:0] freq_o,
  output logic                period_we_o,
  output logic [7:0]          slow_period_o,
  output logic [7:0]          fast_period_o,
  output logic                data_we_o,
  output logic [DATA_BIT-1:0] data_o,
  output logic [CH_W-1:0]     ch_o,
  output logic                ctrl_we_o,
  output logic                mode_o,
  output logic                en_o,
  output logic                err_tick_o,
  output logic [1:0]          err_code_o,
  output logic                busy_o
);

  localparam int         TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] K_DATA  = 2'd0;
  localparam logic [1:0] K_CTRL  = 2'd1;
  localparam logic [1:0] K_FREQ  = 2'd2;
  localparam logic [1:0] K_PER   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHAN    = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_kind;
  logic [2:0]            r_cnt;
  logic [2:0]            r_len;
  logic                  r_bad;
  logic [CH_W-1:0]       r_ch;
  logic [DATA_BIT-9:0]   r_shift;
  logic [TMO_W-1:0]      r_tmo;

  logic [DATA_BIT-1:0]   w_word;
  logic                  w_last;
  logic                  w_timeout;

  // Payload shifts in from the top so the first byte ends up in bits [7:0].
  always_comb begin
    w_word    = {data_i, r_shift};
    w_last    = (r_cnt == r_len);
    w_timeout = (r_state != S_IDLE) && !rx_done_tick_i && (r_tmo == TMO_W'(TIMEOUT_CYC));
  end

  assign busy_o = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state       <= S_IDLE;
      r_kind        <= K_DATA;
      r_cnt         <= 3'd0;
      r_len         <= 3'd0;
      r_bad         <= 1'b0;
      r_ch          <= '0;
      r_shift       <= '0;
      r_tmo         <= '0;
      freq_we_o     <= 1'b0;
      freq_o        <= '0;
      period_we_o   <= 1'b0;
      slow_period_o <= DEF_SLOW;
      fast_period_o <= DEF_FAST;
      data_we_o     <= 1'b0;
      data_o        <= '0;
      ch_o          <= '0;
      ctrl_we_o     <= 1'b0;
      mode_o        <= 1'b0;
      en_o          <= 1'b0;
      err_tick_o    <= 1'b0;
      err_code_o    <= 2'd0;
    end else begin
      freq_we_o   <= 1'b0;
      period_we_o <= 1'b0;
      data_we_o   <= 1'b0;
      ctrl_we_o   <= 1'b0;
      err_tick_o  <= 1'b0;

      if (r_state == S_IDLE || rx_done_tick_i)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 1'b1;

      if (w_timeout) begin
        r_state    <= S_IDLE;
        err_tick_o <= 1'b1;
        err_code_o <= 2'd3;
      end else if (rx_done_tick_i) begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= 3'd0;
            r_bad <= 1'b0;
            if (data_i == CMD_DATA) begin
              r_kind  <= K_DATA;
              r_len   <= 3'd3;
              r_state <= S_CHAN;
            end else if (data_i == CMD_CTRL) begin
              r_kind  <= K_CTRL;
              r_len   <= 3'd0;
              r_state <= S_CHAN;
            end else if (data_i == CMD_FREQ) begin
              r_kind  <= K_FREQ;
              r_len   <= 3'd3;
              r_state <= S_PAYLOAD;
            end else if (data_i == CMD_PERIOD) begin
              r_kind  <= K_PER;
              r_len   <= 3'd1;
              r_state <= S_PAYLOAD;
            end else begin
              err_tick_o <= 1'b1;
              err_code_o <= 2'd1;
            end
          end
          S_CHAN: begin
            r_ch    <= data_i[CH_W-1:0];
            r_state <= S_PAYLOAD;
            // A bad channel still swallows its payload so framing stays aligned.
            if (int'(data_i) >= OUTPUT_NUM) begin
              r_bad      <= 1'b1;
              err_tick_o <= 1'b1;
              err_code_o <= 2'd2;
            end
          end
          S_PAYLOAD: begin
            r_shift <= w_word[DATA_BIT-1:8];
            r_cnt   <= r_cnt + 3'd1;
            if (w_last) begin
              r_state <= S_IDLE;
              if (!r_bad) begin
                case (r_kind)
                  K_DATA: begin
                    data_o    <= w_word;
                    ch_o      <= r_ch;
                    data_we_o <= 1'b1;
                  end
                  K_CTRL: begin
                    mode_o    <= data_i[1];
                    en_o      <= data_i[0];
                    ch_o      <= r_ch;
                    ctrl_we_o <= 1'b1;
                  end
                  K_FREQ: begin
                    freq_o    <= w_word;
                    freq_we_o <= 1'b1;
                  end
                  default: begin
                    slow_period_o <= r_shift[DATA_BIT-9 -: 8];
                    fast_period_o <= data_i;
                    period_we_o   <= 1'b1;
                  end
                endcase
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cmd_frame_parser.md
CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 Parameter DATA_BIT, default 32: pattern width; always 4 payload bytes.
REQ-002 Parameter OUTPUT_NUM, default 16: number of serial output channels; CH_W = clog2(OUTPUT_NUM).
REQ-003 Parameter TIMEOUT_CYC, default 100000: maximum number of idle clk cycles allowed between bytes of one frame.
REQ-004 Parameters CMD_DATA / CMD_CTRL / CMD_FREQ / CMD_PERIOD, defaults 8'h01 / 8'h02 / 8'h03 / 8'h04: command opcodes.
REQ-005 Parameters DEF_SLOW / DEF_FAST, defaults 8'h14 / 8'h05: period reset values.
REQ-006 clk  in  1  system clock, rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-high.
REQ-008 data_i  in  8  received UART byte, valid only while rx_done_tick_i=1.
REQ-009 rx_done_tick_i  in  1  one-cycle byte-valid strobe.
REQ-010 freq_we_o  out  1  one-cycle strobe: freq_o updated.
REQ-011 freq_o  out  DATA_BIT  frequency-select pattern.
REQ-012 period_we_o  out  1  one-cycle strobe: period outputs updated.
REQ-013 slow_period_o, fast_period_o  out  8 each  period values.
REQ-014 data_we_o  out  1  one-cycle strobe: data_o/ch_o valid.
REQ-015 data_o  out  DATA_BIT  channel data pattern.
REQ-016 ch_o  out  CH_W  target channel for data_we_o / ctrl_we_o.
REQ-017 ctrl_we_o  out  1  one-cycle strobe: mode_o/en_o valid.
REQ-018 mode_o, en_o  out  1 each  0 = one-shot / 1 = repeat; channel enable.
REQ-019 err_tick_o  out  1  one-cycle error strobe.
REQ-020 err_code_o  out  2  1 = unknown opcode, 2 = bad channel, 3 = timeout; held until the next error.
REQ-021 busy_o  out  1  high while a frame is in progress (state != IDLE).

Function
REQ-022 FSM states: IDLE, CHAN, PAYLOAD. A byte is consumed only in a cycle where rx_done_tick_i=1.
REQ-023 IDLE: CMD_DATA or CMD_CTRL -> CHAN; CMD_FREQ -> PAYLOAD (4 bytes); CMD_PERIOD -> PAYLOAD (2 bytes); any other value -> stay IDLE, err_tick_o=1, err_code_o=1.
REQ-024 CHAN: latch byte[CH_W-1:0] as the channel; -> PAYLOAD (4 bytes for DATA, 1 byte for CTRL).
REQ-025 CHAN: byte >= OUTPUT_NUM -> err_tick_o=1, err_code_o=2; frame marked bad; payload still consumed; commit strobe suppressed.
REQ-026 PAYLOAD: bytes are assembled LSB first (first byte -> bits[7:0]) using a 3-bit byte counter; on the final byte -> IDLE and commit.
REQ-027 Commit: the output register update and the single strobe occur in the cycle after the final byte's rx_done_tick_i (latency 1 clk).
REQ-028 PERIOD frame: byte1 -> slow_period_o, byte2 -> fast_period_o.
REQ-029 CTRL frame: mode_o = byte[1], en_o = byte[0]; byte[7:2] ignored.
REQ-030 Outputs are registered; value outputs hold their last committed value; strobes never exceed one cycle; at most one strobe is active per cycle.
REQ-031 Timeout counter: cleared on every rx_done_tick_i and while IDLE; increments otherwise.
- On reaching TIMEOUT_CYC: -> IDLE, partial frame discarded, err_tick_o=1, err_code_o=3.
REQ-032 rx_done_tick_i in the same cycle the timeout is reached: the byte is accepted and no timeout occurs.
REQ-033 Frames are not queued; the parser accepts one byte per tick regardless of any commit in progress.

Reset
REQ-034 While rst_n=1: FSM -> IDLE; counters = 0; all strobes = 0; freq_o = 0; data_o = 0; ch_o = 0; mode_o = 0; en_o = 0; slow_period_o = DEF_SLOW; fast_period_o = DEF_FAST; err_code_o = 0; busy_o = 0.
REQ-035 Reset asserted mid-frame discards the partial frame with no strobe and no error.

Verification
REQ-036 Bytes 03,55,55,55,55 -> freq_o = 32'h5555_5555; freq_we_o high for 1 clk, 1 clk after the 5th tick.
REQ-037 Bytes 04,14,05 -> slow_period_o = 8'h14, fast_period_o = 8'h05, period_we_o pulse; then 01,0F,78,56,34,12 -> data_o = 32'h1234_5678, ch_o = 15, data_we_o pulse.
REQ-038 Bytes 02,03,02 -> ch_o = 3, mode_o = 1, en_o = 0, ctrl_we_o pulse; byte 7F in IDLE -> err_code_o = 1, no strobe, busy_o = 0.
REQ-039 Bytes 01,10,AA,BB,CC,DD -> err_code_o = 2 at the channel byte; no data_we_o; the next frame 03,... decodes correctly.
REQ-040 Bytes 03,11 then silence for TIMEOUT_CYC -> err_code_o = 3, busy_o = 0; next 03,01,00,00,00 -> freq_o = 1. A byte arriving exactly in the timeout cycle -> no error.
REQ-041 rst_n pulsed high after 01,02,33 -> no strobe; all outputs at their REQ-034 values.
